// File: rtl/slm_line_reader.sv
// Pulls one line of 32-bit words per controller handshake from the sc32 FIFO and
// re-times them into a framed, optionally inverted pixel stream for the SLM panel.
module slm_line_reader #(
  parameter int WORDS_PER_LINE  = 40,
  parameter int LINES_PER_FRAME = 1024,
  parameter int LINE_GAP        = 4,
  parameter int LINE_IDX_W      = 11
) (
  input  logic                  fpga_clk,
  input  logic                  reset_all,
  input  logic                  update,
  input  logic                  invert,
  input  logic                  line_of_data_available,
  output logic                  get_next_word,
  input  logic [31:0]           word_in,
  output logic [31:0]           slm_data,
  output logic                  slm_data_valid,
  output logic                  slm_line_start,
  output logic                  slm_frame_start,
  output logic [LINE_IDX_W-1:0] slm_line_index,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int WORD_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int GAP_W  = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam logic [WORD_W-1:0]     WORD_LAST = WORD_W'(WORDS_PER_LINE - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(LINE_GAP - 1);
  localparam logic [LINE_IDX_W-1:0] LINE_LAST = LINE_IDX_W'(LINES_PER_FRAME - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LINE, READ, GAP} state_t;

  state_t                state_q;
  logic [WORD_W-1:0]     word_q;
  logic [GAP_W-1:0]      gap_q;
  logic [LINE_IDX_W-1:0] line_q;
  logic                  inv_q;
  logic                  gnw_q;
  logic                  busy_q;

  // Stage 1: metadata of the word being read, aligned with word_in.
  logic                  rd_valid_q;
  logic                  rd_line_start_q;
  logic                  rd_frame_start_q;
  logic                  rd_frame_done_q;
  logic [LINE_IDX_W-1:0] rd_line_q;

  // Stage 2: registered panel outputs.
  logic [31:0]           slm_data_q;
  logic                  slm_valid_q;
  logic                  slm_line_start_q;
  logic                  slm_frame_start_q;
  logic                  frame_done_q;
  logic [LINE_IDX_W-1:0] slm_line_q;

  logic [31:0]           slm_data_d;

  assign slm_data_d = word_in ^ {32{inv_q}};

  always_ff @(posedge fpga_clk) begin
    if (reset_all) begin
      state_q <= IDLE;
      word_q  <= '0;
      gap_q   <= '0;
      line_q  <= '0;
      inv_q   <= 1'b0;
      gnw_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (update) begin
            inv_q   <= invert;
            line_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= WAIT_LINE;
          end
        end
        WAIT_LINE: begin
          if (line_of_data_available) begin
            word_q  <= '0;
            gnw_q   <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (word_q == WORD_LAST) begin
            gnw_q   <= 1'b0;
            gap_q   <= '0;
            state_q <= GAP;
          end else begin
            word_q <= word_q + WORD_W'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            // Clearing instead of incrementing past the last line keeps the index in range.
            if (line_q == LINE_LAST) begin
              line_q  <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              line_q  <= line_q + LINE_IDX_W'(1);
              state_q <= WAIT_LINE;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (reset_all) begin
      rd_valid_q        <= 1'b0;
      rd_line_start_q   <= 1'b0;
      rd_frame_start_q  <= 1'b0;
      rd_frame_done_q   <= 1'b0;
      rd_line_q         <= '0;
      slm_data_q        <= '0;
      slm_valid_q       <= 1'b0;
      slm_line_start_q  <= 1'b0;
      slm_frame_start_q <= 1'b0;
      frame_done_q      <= 1'b0;
      slm_line_q        <= '0;
    end else begin
      rd_valid_q       <= gnw_q;
      rd_line_start_q  <= gnw_q && (word_q == '0);
      rd_frame_start_q <= gnw_q && (word_q == '0) && (line_q == '0);
      rd_frame_done_q  <= gnw_q && (word_q == WORD_LAST) && (line_q == LINE_LAST);
      rd_line_q        <= gnw_q ? line_q : '0;

      slm_data_q        <= rd_valid_q ? slm_data_d : '0;
      slm_valid_q       <= rd_valid_q;
      slm_line_start_q  <= rd_line_start_q;
      slm_frame_start_q <= rd_frame_start_q;
      frame_done_q      <= rd_frame_done_q;
      slm_line_q        <= rd_line_q;
    end
  end

  assign get_next_word   = gnw_q;
  assign busy            = busy_q;
  assign slm_data        = slm_data_q;
  assign slm_data_valid  = slm_valid_q;
  assign slm_line_start  = slm_line_start_q;
  assign slm_frame_start = slm_frame_start_q;
  assign frame_done      = frame_done_q;
  assign slm_line_index  = slm_line_q;

endmodule

// File: tb/tb_slm_line_reader.sv
// Randomized bench for slm_line_reader: a FIFO responder plus a per-frame queue of
// expected pixels built from the framing rules.
module tb_slm_line_reader;

  localparam int WPL    = 4;
  localparam int LPF    = 2;
  localparam int GAPC   = 2;
  localparam int LIDX_W = 11;

  logic              fpga_clk = 1'b0;
  logic              reset_all = 1'b1;
  logic              update = 1'b0;
  logic              invert = 1'b0;
  logic              line_of_data_available = 1'b1;
  logic              get_next_word;
  logic [31:0]       word_in = '0;
  logic [31:0]       slm_data;
  logic              slm_data_valid;
  logic              slm_line_start;
  logic              slm_frame_start;
  logic [LIDX_W-1:0] slm_line_index;
  logic              frame_done;
  logic              busy;

  always #5 fpga_clk = ~fpga_clk;

  slm_line_reader #(
    .WORDS_PER_LINE (WPL),
    .LINES_PER_FRAME(LPF),
    .LINE_GAP       (GAPC),
    .LINE_IDX_W     (LIDX_W)
  ) dut (
    .fpga_clk              (fpga_clk),
    .reset_all             (reset_all),
    .update                (update),
    .invert                (invert),
    .line_of_data_available(line_of_data_available),
    .get_next_word         (get_next_word),
    .word_in               (word_in),
    .slm_data              (slm_data),
    .slm_data_valid        (slm_data_valid),
    .slm_line_start        (slm_line_start),
    .slm_frame_start       (slm_frame_start),
    .slm_line_index        (slm_line_index),
    .frame_done            (frame_done),
    .busy                  (busy)
  );

  typedef struct packed {
    logic              fs;
    logic              ls;
    logic              fd;
    logic [LIDX_W-1:0] idx;
    logic [31:0]       data;
  } pix_t;

  pix_t        exp_q[$];
  logic [31:0] src_q[$];

  int checks = 0;
  int failures = 0;
  int strobes_left = 0;
  int strobes_done = 0;
  int run_len = 0;
  int idle_len = 0;
  bit had_burst = 0;
  bit prev_gnw = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: respond as the FIFO, then score everything the DUT shows this cycle.
  task automatic cycle();
    pix_t o;
    pix_t e;
    @(posedge fpga_clk);
    #1;
    if (reset_all) begin
      chk("reset_outputs",
          64'({get_next_word, slm_data_valid, slm_data, slm_line_start, slm_frame_start,
               slm_line_index, frame_done, busy}), 64'd0);
      src_q.delete();
      exp_q.delete();
      strobes_left = 0;
      run_len = 0;
      idle_len = 0;
      had_burst = 0;
      prev_gnw = 0;
      word_in = $urandom;
    end else begin
      if (prev_gnw && src_q.size() > 0) word_in = src_q.pop_front();
      else word_in = $urandom;

      o = {slm_frame_start, slm_line_start, frame_done, slm_line_index, slm_data};
      if (slm_data_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("pixel", 64'(o), 64'(e));
        end
      end else begin
        chk("idle_markers", 64'({slm_line_start, slm_frame_start, frame_done}), 64'd0);
      end

      if (get_next_word) begin
        if (strobes_left == 0) chk("extra_strobe", 64'd1, 64'd0);
        else strobes_left--;
        strobes_done++;
        if (!prev_gnw && had_burst) chk("line_gap", 64'(idle_len >= GAPC + 1), 64'd1);
        run_len++;
        idle_len = 0;
      end else begin
        if (prev_gnw) begin
          chk("burst_len", 64'(run_len), 64'(WPL));
          had_burst = 1;
        end
        run_len = 0;
        idle_len++;
      end
      prev_gnw = get_next_word;
    end
    invert = 1'($urandom_range(0, 1));
  endtask

  // Builds the whole frame's FIFO contents and expected pixels, then pulses update.
  task automatic start_frame(input logic inv, input int mode);
    pix_t        e;
    logic [31:0] d;
    int          n = 0;
    for (int l = 0; l < LPF; l++) begin
      for (int w = 0; w < WPL; w++) begin
        case (mode)
          0:       d = 32'(n);
          1:       d = 32'h0000FFFF;
          default: d = $urandom;
        endcase
        src_q.push_back(d);
        e.data = d ^ {32{inv}};
        e.idx  = LIDX_W'(l);
        e.ls   = (w == 0);
        e.fs   = (w == 0) && (l == 0);
        e.fd   = (w == WPL - 1) && (l == LPF - 1);
        exp_q.push_back(e);
        n++;
      end
    end
    strobes_left += WPL * LPF;
    strobes_done = 0;
    chk("start_idle", 64'(busy), 64'd0);
    update = 1'b1;
    invert = inv;
    cycle();
    update = 1'b0;
    chk("busy_after_update", 64'(busy), 64'd1);
  endtask

  task automatic run_frame();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      cycle();
      n++;
    end
    chk("frame_complete", 64'(exp_q.size()), 64'd0);
    chk("strobes_all_used", 64'(strobes_left), 64'd0);
    chk("busy_after_frame", 64'(busy), 64'd0);
  endtask

  task automatic wait_strobes(input int target);
    int n = 0;
    while (strobes_done < target && n < 500) begin
      cycle();
      n++;
    end
    chk("strobe_wait", 64'(strobes_done), 64'(target));
  endtask

  initial begin
    int k;

    // Reset held with random inputs, including an update pulse.
    reset_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      update = 1'($urandom_range(0, 1));
      line_of_data_available = 1'($urandom_range(0, 1));
      cycle();
    end
    if (update == 1'b0) begin
      update = 1'b1;
      cycle();
    end
    reset_all = 1'b0;
    update = 1'b0;
    line_of_data_available = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("post_reset_idle", 64'({get_next_word, busy}), 64'd0);
    end

    // Counting pattern frame.
    start_frame(1'b0, 0);
    run_frame();

    // Inverted frame with the invert input wandering mid-frame, then a plain one.
    start_frame(1'b1, 1);
    run_frame();
    start_frame(1'b0, 1);
    run_frame();

    // Stall before line 1.
    start_frame(1'($urandom_range(0, 1)), 2);
    wait_strobes(WPL);
    line_of_data_available = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("stall_no_strobe", 64'(get_next_word), 64'd0);
    end
    line_of_data_available = 1'b1;
    k = 0;
    while (!get_next_word && k < 3) begin
      cycle();
      k++;
    end
    chk("stall_resume", 64'(k <= 2), 64'd1);
    run_frame();

    // update during READ is dropped; only one frame comes out.
    start_frame(1'($urandom_range(0, 1)), 2);
    wait_strobes(2);
    update = 1'b1;
    cycle();
    update = 1'b0;
    run_frame();
    for (int i = 0; i < 12; i++) cycle();

    // Reset after strobe 2 of line 1 discards everything in flight.
    start_frame(1'($urandom_range(0, 1)), 2);
    wait_strobes(WPL + 2);
    reset_all = 1'b1;
    cycle();
    reset_all = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("idle_after_reset", 64'({get_next_word, busy}), 64'd0);
    start_frame(1'b0, 0);
    run_frame();

    for (int f = 0; f < 3; f++) begin
      start_frame(1'($urandom_range(0, 1)), 2);
      run_frame();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
